// File: rtl/ibex_wb_queue.sv
// Multi-entry in-order writeback queue between ID/EX and the register file.
// Loads and stores wait at the head for their LSU response while ID/EX keeps
// issuing. Read ports see forwarding data or a load-use hazard taken from
// every queued entry.

package ibex_wb_pkg;
    typedef enum logic [1:0] {
        WB_INSTR_LOAD  = 2'd0,
        WB_INSTR_STORE = 2'd1,
        WB_INSTR_OTHER = 2'd2
    } wb_instr_type_e;
endpackage

module ibex_wb_queue
    import ibex_wb_pkg::*;
#(
    parameter int NumEntries = 2,
    parameter int RegAddrW   = 5,
    parameter int DataW      = 32,
    localparam int PtrW      = (NumEntries > 1) ? $clog2(NumEntries) : 1,
    localparam int CntW      = $clog2(NumEntries + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_wb_i,
    input  wb_instr_type_e      instr_type_wb_i,
    input  logic [DataW-1:0]    pc_id_i,
    input  logic [RegAddrW-1:0] rf_waddr_id_i,
    input  logic [DataW-1:0]    rf_wdata_id_i,
    input  logic                rf_we_id_i,
    input  logic [DataW-1:0]    rf_wdata_lsu_i,
    input  logic                rf_we_lsu_i,
    input  logic                lsu_data_valid_i,
    input  logic [RegAddrW-1:0] rf_raddr_a_i,
    input  logic [RegAddrW-1:0] rf_raddr_b_i,
    output logic                ready_wb_o,
    output logic                fwd_valid_a_o,
    output logic                fwd_valid_b_o,
    output logic [DataW-1:0]    fwd_data_a_o,
    output logic [DataW-1:0]    fwd_data_b_o,
    output logic                hazard_a_o,
    output logic                hazard_b_o,
    output logic                outstanding_load_wb_o,
    output logic                outstanding_store_wb_o,
    output logic [DataW-1:0]    pc_wb_o,
    output logic                instr_done_wb_o,
    output logic [RegAddrW-1:0] rf_waddr_wb_o,
    output logic [DataW-1:0]    rf_wdata_wb_o,
    output logic                rf_we_wb_o,
    output logic [CntW-1:0]     count_o
);

    // Entry storage: only the valid bits are reset, payload is don't-care
    // until the matching valid bit is set.
    logic                valid_q [NumEntries];
    wb_instr_type_e      type_q  [NumEntries];
    logic [DataW-1:0]    pc_q    [NumEntries];
    logic [RegAddrW-1:0] waddr_q [NumEntries];
    logic [DataW-1:0]    wdata_q [NumEntries];
    logic                we_q    [NumEntries];

    logic [PtrW-1:0] head_q, tail_q;
    logic [CntW-1:0] count_q;

    logic            head_valid;
    wb_instr_type_e  head_type;
    logic            head_done;
    logic            push, pop;
    logic            queue_we, lsu_we;

    // Pointer wrap uses an explicit compare so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(NumEntries - 1)) return '0;
        return p + 1'b1;
    endfunction

    // Youngest matching writer wins: walk from head towards tail so later
    // (younger) hits overwrite earlier ones. Result is {hazard, fwd_valid, data}.
    function automatic logic [DataW+1:0] fwd_lookup(input logic [RegAddrW-1:0] raddr);
        logic             hit;
        logic             is_load;
        logic [DataW-1:0] data;
        int               idx;
        logic [PtrW-1:0]  sel;
        hit     = 1'b0;
        is_load = 1'b0;
        data    = '0;
        for (int k = 0; k < NumEntries; k++) begin
            idx = int'(head_q) + k;
            if (idx >= NumEntries) idx = idx - NumEntries;
            sel = PtrW'(idx);
            if (valid_q[sel] && (waddr_q[sel] == raddr) && (raddr != '0) &&
                (we_q[sel] || (type_q[sel] == WB_INSTR_LOAD))) begin
                hit     = 1'b1;
                is_load = (type_q[sel] == WB_INSTR_LOAD);
                data    = wdata_q[sel];
            end
        end
        // A load match never forwards: its data only exists on the LSU side.
        return {hit & is_load, hit & ~is_load, (hit & ~is_load) ? data : '0};
    endfunction

    assign head_valid = valid_q[head_q];
    assign head_type  = type_q[head_q];
    assign head_done  = head_valid &
                        ((head_type == WB_INSTR_OTHER) | lsu_data_valid_i);

    assign ready_wb_o = (count_q < CntW'(NumEntries)) | head_done;
    assign push       = en_wb_i & ready_wb_o;
    assign pop        = head_done;

    assign instr_done_wb_o = head_valid & head_done;
    assign pc_wb_o         = head_valid ? pc_q[head_q] : '0;
    assign count_o         = count_q;

    // Two RF write sources; types are exclusive so they never overlap.
    assign queue_we = head_valid & (head_type == WB_INSTR_OTHER) & we_q[head_q];
    assign lsu_we   = head_valid & (head_type == WB_INSTR_LOAD) & rf_we_lsu_i;

    // RF write port mux: queue result first, LSU load data otherwise.
    always_comb begin
        rf_waddr_wb_o = '0;
        rf_wdata_wb_o = '0;
        rf_we_wb_o    = 1'b0;
        if (head_valid) begin
            rf_waddr_wb_o = waddr_q[head_q];
            if (queue_we) begin
                rf_wdata_wb_o = wdata_q[head_q];
                rf_we_wb_o    = 1'b1;
            end else begin
                rf_wdata_wb_o = rf_wdata_lsu_i;
                rf_we_wb_o    = lsu_we;
            end
        end
    end

    // Per-port forwarding and load-use hazard detection.
    always_comb begin
        {hazard_a_o, fwd_valid_a_o, fwd_data_a_o} = fwd_lookup(rf_raddr_a_i);
        {hazard_b_o, fwd_valid_b_o, fwd_data_b_o} = fwd_lookup(rf_raddr_b_i);
    end

    // Outstanding memory operations anywhere in the queue.
    always_comb begin
        outstanding_load_wb_o  = 1'b0;
        outstanding_store_wb_o = 1'b0;
        for (int i = 0; i < NumEntries; i++) begin
            if (valid_q[i] && type_q[i] == WB_INSTR_LOAD)  outstanding_load_wb_o  = 1'b1;
            if (valid_q[i] && type_q[i] == WB_INSTR_STORE) outstanding_store_wb_o = 1'b1;
        end
    end

    // Control state: valid bits, pointers and occupancy. The pop clears
    // first so a full-queue push into the same slot wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumEntries; i++) valid_q[i] <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= ptr_inc(head_q);
            end
            if (push) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= ptr_inc(tail_q);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload capture at the tail slot; no reset needed.
    always_ff @(posedge clk_i) begin
        if (push) begin
            type_q[tail_q]  <= instr_type_wb_i;
            pc_q[tail_q]    <= pc_id_i;
            waddr_q[tail_q] <= rf_waddr_id_i;
            wdata_q[tail_q] <= rf_wdata_id_i;
            we_q[tail_q]    <= rf_we_id_i;
        end
    end

    // An LSU response is only meaningful for a load/store at the head.
    lsu_resp_at_mem_head: assert property (@(posedge clk_i) disable iff (rst_i)
        lsu_data_valid_i |-> (head_valid && head_type != WB_INSTR_OTHER));

    // Queue result and LSU result must never drive the RF together.
    rf_single_source: assert property (@(posedge clk_i) disable iff (rst_i)
        !(queue_we && lsu_we));

endmodule

// File: tb/tb_ibex_wb_queue.sv
// Directed bench: a depth-2 and a depth-3 queue share one stimulus stream.
module tb_ibex_wb_queue;
    import ibex_wb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic           en, we, lsu_we, lsu_valid;
    wb_instr_type_e typ;
    logic [31:0]    pc, wdata, lsu_wdata;
    logic [4:0]     waddr, raddr_a, raddr_b;

    logic        ready2, fva2, fvb2, hza2, hzb2, ol2, os2, done2, rfwe2;
    logic [31:0] fda2, fdb2, pcwb2, rfwd2;
    logic [4:0]  rfwa2;
    logic [1:0]  cnt2;

    logic        ready3, fva3, fvb3, hza3, hzb3, ol3, os3, done3, rfwe3;
    logic [31:0] fda3, fdb3, pcwb3, rfwd3;
    logic [4:0]  rfwa3;
    logic [1:0]  cnt3;

    int vectors = 0;
    int miscompares = 0;

    ibex_wb_queue #(.NumEntries(2), .RegAddrW(5), .DataW(32)) dut2 (
        .clk_i(clk), .rst_i(rst), .en_wb_i(en), .instr_type_wb_i(typ),
        .pc_id_i(pc), .rf_waddr_id_i(waddr), .rf_wdata_id_i(wdata), .rf_we_id_i(we),
        .rf_wdata_lsu_i(lsu_wdata), .rf_we_lsu_i(lsu_we), .lsu_data_valid_i(lsu_valid),
        .rf_raddr_a_i(raddr_a), .rf_raddr_b_i(raddr_b), .ready_wb_o(ready2),
        .fwd_valid_a_o(fva2), .fwd_valid_b_o(fvb2), .fwd_data_a_o(fda2), .fwd_data_b_o(fdb2),
        .hazard_a_o(hza2), .hazard_b_o(hzb2), .outstanding_load_wb_o(ol2),
        .outstanding_store_wb_o(os2), .pc_wb_o(pcwb2), .instr_done_wb_o(done2),
        .rf_waddr_wb_o(rfwa2), .rf_wdata_wb_o(rfwd2), .rf_we_wb_o(rfwe2), .count_o(cnt2));

    ibex_wb_queue #(.NumEntries(3), .RegAddrW(5), .DataW(32)) dut3 (
        .clk_i(clk), .rst_i(rst), .en_wb_i(en), .instr_type_wb_i(typ),
        .pc_id_i(pc), .rf_waddr_id_i(waddr), .rf_wdata_id_i(wdata), .rf_we_id_i(we),
        .rf_wdata_lsu_i(lsu_wdata), .rf_we_lsu_i(lsu_we), .lsu_data_valid_i(lsu_valid),
        .rf_raddr_a_i(raddr_a), .rf_raddr_b_i(raddr_b), .ready_wb_o(ready3),
        .fwd_valid_a_o(fva3), .fwd_valid_b_o(fvb3), .fwd_data_a_o(fda3), .fwd_data_b_o(fdb3),
        .hazard_a_o(hza3), .hazard_b_o(hzb3), .outstanding_load_wb_o(ol3),
        .outstanding_store_wb_o(os3), .pc_wb_o(pcwb3), .instr_done_wb_o(done3),
        .rf_waddr_wb_o(rfwa3), .rf_wdata_wb_o(rfwd3), .rf_we_wb_o(rfwe3), .count_o(cnt3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change #1 after a rising edge; checks happen #4 later, before
    // the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic drive(input logic e, input wb_instr_type_e t, input logic [31:0] p,
                         input logic [4:0] a, input logic [31:0] d, input logic w);
        en = e; typ = t; pc = p; waddr = a; wdata = d; we = w;
    endtask

    initial begin
        drive(1'b1, WB_INSTR_OTHER, 32'h100, 5'd1, 32'hAA, 1'b1);
        lsu_wdata = '0; lsu_we = 1'b0; lsu_valid = 1'b0;
        raddr_a = '0; raddr_b = '0;

        // Reset held with en asserted
        repeat (2) @(posedge clk);
        #1; settle();
        chk("rst_count2", 32'(cnt2), 32'd0);
        chk("rst_rfwe2", 32'(rfwe2), 32'd0);
        chk("rst_ready2", 32'(ready2), 32'd1);
        chk("rst_pcwb2", pcwb2, 32'h0);
        chk("rst_count3", 32'(cnt3), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        settle();
        chk("first_pre_count", 32'(cnt2), 32'd0);
        chk("first_pre_done", 32'(done2), 32'd0);
        tick();
        en = 1'b0;
        settle();
        chk("first_count", 32'(cnt2), 32'd1);
        chk("first_done", 32'(done2), 32'd1);
        chk("first_rfwe", 32'(rfwe2), 32'd1);
        chk("first_waddr", 32'(rfwa2), 32'd1);
        chk("first_wdata", rfwd2, 32'hAA);
        chk("first_pcwb", pcwb2, 32'h100);
        tick();
        settle();
        chk("first_drain", 32'(cnt2), 32'd0);

        // LOAD x5 then OTHER x6=0x1234, no LSU response
        drive(1'b1, WB_INSTR_LOAD, 32'h200, 5'd5, 32'h0, 1'b0);
        tick();
        drive(1'b1, WB_INSTR_OTHER, 32'h204, 5'd6, 32'h1234, 1'b1);
        tick();
        en = 1'b0; raddr_a = 5'd5; raddr_b = 5'd6;
        settle();
        chk("full_count", 32'(cnt2), 32'd2);
        chk("full_ready", 32'(ready2), 32'd0);
        chk("full_outld", 32'(ol2), 32'd1);
        chk("full_haz_a", 32'(hza2), 32'd1);
        chk("full_fva", 32'(fva2), 32'd0);
        chk("full_fvb", 32'(fvb2), 32'd1);
        chk("full_fdb", fdb2, 32'h1234);
        chk("full_done", 32'(done2), 32'd0);
        chk("full_pcwb", pcwb2, 32'h200);
        tick();
        settle();
        chk("stall_count", 32'(cnt2), 32'd2);

        // Load response; same cycle push OTHER x7=0x11 via head retire
        lsu_valid = 1'b1; lsu_we = 1'b1; lsu_wdata = 32'hCAFE;
        drive(1'b1, WB_INSTR_OTHER, 32'h208, 5'd7, 32'h11, 1'b1);
        settle();
        chk("ld_waddr", 32'(rfwa2), 32'd5);
        chk("ld_wdata", rfwd2, 32'hCAFE);
        chk("ld_rfwe", 32'(rfwe2), 32'd1);
        chk("ld_ready", 32'(ready2), 32'd1);
        chk("ld_done", 32'(done2), 32'd1);
        chk("ld_haz_still", 32'(hza2), 32'd1);
        tick();
        lsu_valid = 1'b0; lsu_we = 1'b0; lsu_wdata = '0;

        // Full, head OTHER x6: push x7=0x22 while head retires
        drive(1'b1, WB_INSTR_OTHER, 32'h20C, 5'd7, 32'h22, 1'b1);
        raddr_a = 5'd7; raddr_b = 5'd0;
        settle();
        chk("pp_count", 32'(cnt2), 32'd2);
        chk("pp_ready", 32'(ready2), 32'd1);
        chk("pp_waddr", 32'(rfwa2), 32'd6);
        chk("pp_wdata", rfwd2, 32'h1234);
        chk("pp_fda_one", fda2, 32'h11);
        chk("pp_outld", 32'(ol2), 32'd0);
        tick();
        en = 1'b0;
        settle();
        chk("wrap_count", 32'(cnt2), 32'd2);
        chk("wrap_fva", 32'(fva2), 32'd1);
        chk("wrap_fda_young", fda2, 32'h22);
        chk("wrap_fvb_x0", 32'(fvb2), 32'd0);
        chk("wrap_hzb_x0", 32'(hzb2), 32'd0);
        chk("wrap_wdata", rfwd2, 32'h11);
        chk("wrap_pcwb", pcwb2, 32'h208);
        tick();
        settle();
        chk("drain1_count", 32'(cnt2), 32'd1);
        chk("drain1_wdata", rfwd2, 32'h22);
        chk("drain1_pcwb", pcwb2, 32'h20C);
        tick();
        settle();
        chk("empty_count", 32'(cnt2), 32'd0);
        chk("empty_rfwe", 32'(rfwe2), 32'd0);
        chk("empty_pcwb", pcwb2, 32'h0);
        chk("empty_fva", 32'(fva2), 32'd0);

        // Younger OTHER shadows older LOAD on the same register
        drive(1'b1, WB_INSTR_LOAD, 32'h220, 5'd5, 32'h0, 1'b0);
        raddr_a = 5'd5;
        tick();
        drive(1'b1, WB_INSTR_OTHER, 32'h224, 5'd5, 32'h55, 1'b1);
        tick();
        en = 1'b0;
        settle();
        chk("shadow_haz", 32'(hza2), 32'd0);
        chk("shadow_fva", 32'(fva2), 32'd1);
        chk("shadow_fda", fda2, 32'h55);
        lsu_valid = 1'b1; lsu_we = 1'b1; lsu_wdata = 32'hBEEF;
        settle();
        chk("shadow_ldwd", rfwd2, 32'hBEEF);
        tick();
        lsu_valid = 1'b0; lsu_we = 1'b0;
        tick();

        // STORE at head
        drive(1'b1, WB_INSTR_STORE, 32'h300, 5'd9, 32'h0, 1'b0);
        tick();
        en = 1'b0;
        settle();
        chk("st_count", 32'(cnt2), 32'd1);
        chk("st_outst", 32'(os2), 32'd1);
        chk("st_wait_done", 32'(done2), 32'd0);
        lsu_valid = 1'b1;
        settle();
        chk("st_done", 32'(done2), 32'd1);
        chk("st_rfwe", 32'(rfwe2), 32'd0);
        tick();
        lsu_valid = 1'b0;
        settle();
        chk("st_outst_drop", 32'(os2), 32'd0);
        chk("st_count0", 32'(cnt2), 32'd0);

        // Depth 3: reset, then stream 7 OTHER instructions
        rst = 1'b1; tick(); rst = 1'b0; raddr_a = '0;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, WB_INSTR_OTHER, 32'h400 + 32'(4 * i), 5'(i + 1), 32'h10 + 32'(i), 1'b1);
            settle();
            if (i > 0) begin
                chk($sformatf("s3_waddr%0d", i), 32'(rfwa3), 32'(i));
                chk($sformatf("s3_wdata%0d", i), rfwd3, 32'h10 + 32'(i - 1));
                chk($sformatf("s3_pcwb%0d", i), pcwb3, 32'h400 + 32'(4 * (i - 1)));
                chk($sformatf("s3_count%0d", i), 32'(cnt3), 32'd1);
            end
            tick();
        end
        en = 1'b0;
        settle();
        chk("s3_last_wdata", rfwd3, 32'h16);
        chk("s3_last_pcwb", pcwb3, 32'h418);
        tick();
        settle();
        chk("s3_empty", 32'(cnt3), 32'd0);

        // Depth 3: fill behind a stalled load
        drive(1'b1, WB_INSTR_LOAD, 32'h500, 5'd1, 32'h0, 1'b0);
        tick();
        drive(1'b1, WB_INSTR_OTHER, 32'h504, 5'd2, 32'h2, 1'b1);
        tick();
        drive(1'b1, WB_INSTR_OTHER, 32'h508, 5'd3, 32'h3, 1'b1);
        tick();
        en = 1'b0; raddr_a = 5'd3; raddr_b = 5'd1;
        settle();
        chk("f3_count", 32'(cnt3), 32'd3);
        chk("f3_ready", 32'(ready3), 32'd0);
        chk("f3_fda", fda3, 32'h3);
        chk("f3_hzb", 32'(hzb3), 32'd1);
        lsu_valid = 1'b1; lsu_we = 1'b1; lsu_wdata = 32'hD0;
        settle();
        chk("f3_ready_ld", 32'(ready3), 32'd1);
        chk("f3_ldwd", rfwd3, 32'hD0);
        tick();
        lsu_valid = 1'b0; lsu_we = 1'b0;
        repeat (2) tick();
        settle();
        chk("f3_drained", 32'(cnt3), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout vectors=%0d", vectors);
        $fatal(1, "timeout");
    end
endmodule
